// File: rtl/instruction_dispatcher_pkg.sv
// Shared SSM definitions: opcode map, execution-FSM indices and dispatcher state encoding.
// Execution FSMs import this package as well, so FSM_* indices are the one source of truth.
package ssm_pkg;

  localparam logic [3:0] OP_ALU_LO  = 4'h0;
  localparam logic [3:0] OP_ALU_HI  = 4'h7;
  localparam logic [3:0] OP_MOVE    = 4'h8;
  localparam logic [3:0] OP_ALUI_LO = 4'h9;
  localparam logic [3:0] OP_ALUI_HI = 4'hA;
  localparam logic [3:0] OP_MOVI    = 4'hB;
  localparam logic [3:0] OP_LOAD    = 4'hC;
  localparam logic [3:0] OP_STORE   = 4'hD;
  localparam logic [3:0] OP_NOP     = 4'hE;
  localparam logic [3:0] OP_HALT    = 4'hF;

  localparam int FSM_ALU   = 0;
  localparam int FSM_MOVE  = 1;
  localparam int FSM_ALUI  = 2;
  localparam int FSM_MOVI  = 3;
  localparam int FSM_LOAD  = 4;
  localparam int FSM_STORE = 5;
  localparam int NUM_FSM   = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_HALTED = 3'd3,
    ST_FAULT  = 3'd4
  } disp_state_e;

  function automatic logic [NUM_FSM-1:0] fsm_onehot(input int idx);
    logic [NUM_FSM-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/instruction_dispatcher_if.sv
// Instruction-in and start/done-out bundle of the dispatcher.
// instr: a word transfers on a rising edge where instr_valid && instr_ready; start/done: start is a
// one-cycle pulse, done is a level sampled only while the dispatcher waits on that FSM.
interface instruction_dispatcher_if;
  import ssm_pkg::*;

  logic               instr_valid;
  logic [15:0]        instruction;
  logic               instr_ready;
  logic [NUM_FSM-1:0] fsm_start;
  logic [NUM_FSM-1:0] fsm_done;

  modport master (
    output instr_valid, instruction, fsm_done,
    input  instr_ready, fsm_start
  );

  modport slave (
    input  instr_valid, instruction, fsm_done,
    output instr_ready, fsm_start
  );

endinterface

// File: rtl/instruction_dispatcher_decode.sv
// Combinational opcode decode: one-hot execution-FSM target plus NOP/HALT flags.
module dispatch_decode
  import ssm_pkg::*;
(
  input  logic [3:0]         opcode,
  output logic [NUM_FSM-1:0] target,
  output logic               is_nop,
  output logic               is_halt
);

  always_comb begin
    target  = '0;
    is_nop  = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      4'h0, 4'h1, 4'h2, 4'h3,
      4'h4, 4'h5, 4'h6, 4'h7: target = fsm_onehot(FSM_ALU);
      OP_MOVE:                target = fsm_onehot(FSM_MOVE);
      OP_ALUI_LO, OP_ALUI_HI: target = fsm_onehot(FSM_ALUI);
      OP_MOVI:                target = fsm_onehot(FSM_MOVI);
      OP_LOAD:                target = fsm_onehot(FSM_LOAD);
      OP_STORE:               target = fsm_onehot(FSM_STORE);
      OP_NOP:                 is_nop  = 1'b1;
      OP_HALT:                is_halt = 1'b1;
      default:                target = '0;
    endcase
  end

endmodule

// File: rtl/instruction_dispatcher.sv
// SSM front-end sequencer: accepts one instruction, pulses the matching execution FSM's start,
// waits for its done, counts retirements and faults if the FSM never answers.
module instruction_dispatcher
  import ssm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  instruction_dispatcher_if.slave  bus,
  output logic [3:0]               opcode,
  output logic [5:0]               param1,
  output logic [5:0]               param2,
  output logic                     halted,
  output logic                     fault,
  output logic [CNT_W-1:0]         retired,
  output disp_state_e              state
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  disp_state_e        next_state;
  logic [NUM_FSM-1:0] dec_target;
  logic               dec_nop;
  logic               dec_halt;
  logic [NUM_FSM-1:0] target_q;
  logic [WD_W-1:0]    watchdog;
  logic               accept;
  logic               done_hit;
  logic               wd_expired;
  logic               retire_evt;

  dispatch_decode u_decode (
    .opcode  (bus.instruction[15:12]),
    .target  (dec_target),
    .is_nop  (dec_nop),
    .is_halt (dec_halt)
  );

  assign accept     = bus.instr_valid && (state == ST_IDLE);
  // Only the latched target's done counts; done from any other FSM is noise here.
  assign done_hit   = (state == ST_WAIT) && |(bus.fsm_done & target_q);
  assign wd_expired = (watchdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign retire_evt = (accept && (dec_nop || dec_halt)) || done_hit;

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (dec_halt)     next_state = ST_HALTED;
          else if (!dec_nop) next_state = ST_ISSUE;
        end
      end
      ST_ISSUE:  next_state = ST_WAIT;
      ST_WAIT: begin
        if (done_hit)        next_state = ST_IDLE;
        else if (wd_expired) next_state = ST_FAULT;
      end
      ST_HALTED: next_state = ST_HALTED;
      ST_FAULT:  next_state = ST_FAULT;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.instr_ready = (state == ST_IDLE);
    halted          = (state == ST_HALTED);
    fault           = (state == ST_FAULT);
  end

  // Start is loaded on the accepting edge so it is high exactly for the ISSUE cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      opcode        <= '0;
      param1        <= '0;
      param2        <= '0;
      target_q      <= '0;
      bus.fsm_start <= '0;
      watchdog      <= '0;
      retired       <= '0;
    end else begin
      if (accept) begin
        opcode   <= bus.instruction[15:12];
        param1   <= bus.instruction[11:6];
        param2   <= bus.instruction[5:0];
        target_q <= dec_target;
      end
      bus.fsm_start <= (accept && !dec_nop && !dec_halt) ? dec_target : '0;
      if (state == ST_ISSUE)
        watchdog <= '0;
      else if (state == ST_WAIT && !done_hit)
        watchdog <= watchdog + 1'b1;
      if (retire_evt)
        retired <= retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Bench for instruction_dispatcher: table of dispatch vectors, start scoreboard and corner sequences.
module tb_instruction_dispatcher;
  import ssm_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  opcode;
  logic [5:0]  param1;
  logic [5:0]  param2;
  logic        halted;
  logic        fault;
  logic [15:0] retired;
  disp_state_e state;

  instruction_dispatcher_if bus ();

  instruction_dispatcher #(.TIMEOUT_CYCLES(64), .CNT_W(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .opcode  (opcode),
    .param1  (param1),
    .param2  (param2),
    .halted  (halted),
    .fault   (fault),
    .retired (retired),
    .state   (state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] instr;
    logic [5:0]  exp_start;
    int          delay;
    string       name;
  } vec_t;

  vec_t        vecs[8];
  logic [5:0]  exp_q[$];
  logic [15:0] exp_retired;
  int          checks = 0;
  int          errors = 0;
  int          expected_pulses = 0;
  int          start_pulses = 0;
  int          wide_starts = 0;
  logic [5:0]  prev_start = '0;

  // Pulse monitor: counts start pulses and any pulse lasting more than one cycle.
  always @(negedge clock) begin
    if (bus.fsm_start != '0) begin
      start_pulses++;
      if (prev_start != '0) wide_starts++;
    end
    prev_start = bus.fsm_start;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.instr_valid = 1'b0;
    bus.fsm_done = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    exp_retired = '0;
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic send(input logic [15:0] instr);
    int n;
    n = 0;
    while (!bus.instr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus.instr_ready) check("ready_timeout", 32'd0, 32'd1);
    bus.instruction = instr;
    bus.instr_valid = 1'b1;
    @(posedge clock);
    #1 bus.instr_valid = 1'b0;
  endtask

  // Waits for the start pulse, pops the scoreboard and compares; returns at that negedge.
  task automatic expect_start(input string name, input logic [15:0] instr, output logic [5:0] e);
    int n;
    e = '0;
    @(negedge clock);
    n = 0;
    while (bus.fsm_start == '0 && n < 10) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check({name, "_start"}, {26'd0, bus.fsm_start}, {26'd0, e});
    check({name, "_opcode"}, {28'd0, opcode}, {28'd0, instr[15:12]});
    check({name, "_param1"}, {26'd0, param1}, {26'd0, instr[11:6]});
    check({name, "_param2"}, {26'd0, param2}, {26'd0, instr[5:0]});
  endtask

  task automatic run_instr(input vec_t v);
    logic [5:0] e;
    exp_q.push_back(v.exp_start);
    expected_pulses++;
    send(v.instr);
    expect_start(v.name, v.instr, e);
    repeat (v.delay) @(negedge clock);
    bus.fsm_done = v.exp_start;
    @(negedge clock);
    bus.fsm_done = '0;
    exp_retired++;
    check({v.name, "_retired"}, {16'd0, retired}, {16'd0, exp_retired});
    check({v.name, "_ready"}, {31'd0, bus.instr_ready}, 32'd1);
  endtask

  initial begin
    logic [5:0] e;
    int n;

    vecs[0] = '{16'h1042, 6'b000001, 3, "alu"};
    vecs[1] = '{16'h8123, 6'b000010, 1, "move"};
    vecs[2] = '{16'hB3C5, 6'b001000, 2, "movi"};
    vecs[3] = '{16'hC00F, 6'b010000, 1, "load"};
    vecs[4] = '{16'hD7FF, 6'b100000, 4, "store"};
    vecs[5] = '{16'hA555, 6'b000100, 1, "alui_a"};
    vecs[6] = '{16'h9001, 6'b000100, 2, "alui_9"};
    vecs[7] = '{16'h7FFF, 6'b000001, 1, "alu_7"};

    bus.instr_valid = 1'b0;
    bus.instruction = '0;
    bus.fsm_done = '0;
    do_reset();

    check("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    check("rst_start", {26'd0, bus.fsm_start}, 32'd0);
    check("rst_opcode", {28'd0, opcode}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_retired", {16'd0, retired}, 32'd0);

    for (int i = 0; i < 8; i++) run_instr(vecs[i]);

    // NOP retires in one cycle and never pulses a start.
    send(16'hE000);
    @(negedge clock);
    exp_retired++;
    check("nop_retired", {16'd0, retired}, {16'd0, exp_retired});
    check("nop_ready", {31'd0, bus.instr_ready}, 32'd1);
    check("nop_opcode", {28'd0, opcode}, 32'hE);

    // Done coincident with start is missed; a later done completes.
    exp_q.push_back(6'b000001);
    expected_pulses++;
    send(16'h2ABC);
    expect_start("coinc", 16'h2ABC, e);
    bus.fsm_done = 6'b000001;
    @(negedge clock);
    bus.fsm_done = '0;
    check("coinc_still_wait", {29'd0, state}, {29'd0, ST_WAIT});
    bus.fsm_done = 6'b000001;
    @(negedge clock);
    bus.fsm_done = '0;
    exp_retired++;
    check("coinc_idle", {29'd0, state}, {29'd0, ST_IDLE});
    check("coinc_retired", {16'd0, retired}, {16'd0, exp_retired});

    // HALT then ignored instructions.
    send(16'hF000);
    @(negedge clock);
    exp_retired++;
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_ready", {31'd0, bus.instr_ready}, 32'd0);
    check("halt_retired", {16'd0, retired}, {16'd0, exp_retired});
    bus.instruction = 16'h1042;
    bus.instr_valid = 1'b1;
    repeat (5) @(negedge clock);
    bus.instr_valid = 1'b0;
    check("halt_ignore_retired", {16'd0, retired}, {16'd0, exp_retired});
    check("halt_ignore_state", {29'd0, state}, {29'd0, ST_HALTED});
    do_reset();
    check("halt_reset_clear", {31'd0, halted}, 32'd0);

    // Wrong-FSM done ignored, then watchdog fault after 64 WAIT cycles.
    send(16'hE000);
    exp_q.push_back(6'b000001);
    expected_pulses++;
    send(16'h0123);
    expect_start("wd", 16'h0123, e);
    n = 0;
    while (!fault && n < 100) begin
      @(negedge clock);
      n++;
      if (n == 2) bus.fsm_done = 6'b001000;
      if (n == 5) begin
        bus.fsm_done = '0;
        check("wrong_done_wait", {29'd0, state}, {29'd0, ST_WAIT});
      end
    end
    check("wd_fault_cycle", n, 32'd65);
    check("wd_fault", {31'd0, fault}, 32'd1);
    check("wd_ready", {31'd0, bus.instr_ready}, 32'd0);
    check("wd_retired_before_reset", {16'd0, retired}, 32'd1);
    do_reset();
    check("wd_reset_fault", {31'd0, fault}, 32'd0);
    check("wd_reset_retired", {16'd0, retired}, 32'd0);

    // Reset mid-WAIT with a matching done in the same cycle.
    send(16'hE000);
    exp_q.push_back(6'b000001);
    expected_pulses++;
    send(16'h0FC3);
    expect_start("midwait", 16'h0FC3, e);
    @(negedge clock);
    reset = 1'b0;
    bus.fsm_done = 6'b000001;
    @(negedge clock);
    check("midwait_state", {29'd0, state}, {29'd0, ST_IDLE});
    check("midwait_retired", {16'd0, retired}, 32'd0);
    check("midwait_opcode", {28'd0, opcode}, 32'd0);
    check("midwait_param1", {26'd0, param1}, 32'd0);
    check("midwait_start", {26'd0, bus.fsm_start}, 32'd0);
    reset = 1'b1;
    bus.fsm_done = '0;
    @(negedge clock);
    check("midwait_after", {16'd0, retired}, 32'd0);

    // Retire counter wrap.
    do_reset();
    bus.instruction = 16'hE000;
    bus.instr_valid = 1'b1;
    repeat (65535) @(posedge clock);
    #1 bus.instr_valid = 1'b0;
    @(negedge clock);
    check("wrap_ffff", {16'd0, retired}, 32'hFFFF);
    send(16'hE000);
    @(negedge clock);
    check("wrap_zero", {16'd0, retired}, 32'h0);

    check("start_pulse_count", start_pulses, expected_pulses);
    check("start_pulse_width", wide_starts, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
